initial_logic: RTL

//   Ingress half of the transmission layer. Buffers incoming 6-bit words in a main FIFO and routes each word by its

---
 rtl/initial_logic.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/initial_logic.sv
// Ingress stage: main FIFO feeding two class-routed VC FIFOs with per-VC backpressure.
// Optional build macro INITIAL_LOGIC_STATS_EN adds saturating per-VC transfer counters.
module initial_logic #(
  parameter int data_width   = 6,
  parameter int VC_BIT       = 5,
  parameter int main_aw      = 3,
  parameter int vc_aw        = 4,
  parameter int vc_af_margin = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [data_width-1:0] data_in,
  input  logic                  push_main,
  input  logic                  pop_VC0,
  input  logic                  pop_VC1,
  output logic [data_width-1:0] data_out_VC0,
  output logic [data_width-1:0] data_out_VC1,
  output logic                  empty_fifo_VC0,
  output logic                  empty_fifo_VC1,
  output logic                  full_main,
  output logic                  almost_full_main,
  output logic                  error_main,
  output logic                  error_VC0,
  output logic                  error_VC1
`ifdef INITIAL_LOGIC_STATS_EN
  ,
  output logic [7:0]            routed_VC0,
  output logic [7:0]            routed_VC1
`endif
);

  localparam int MAIN_DEPTH = 1 << main_aw;
  localparam int VC_DEPTH   = 1 << vc_aw;
  localparam logic [main_aw:0] MAIN_FULL = (main_aw+1)'(MAIN_DEPTH);
  localparam logic [main_aw:0] MAIN_AF   = (main_aw+1)'(MAIN_DEPTH - 2);
  localparam logic [vc_aw:0]   VC_LIMIT  = (vc_aw+1)'(VC_DEPTH - vc_af_margin);

  // Main FIFO
  logic [data_width-1:0] main_mem [MAIN_DEPTH];
  logic [main_aw-1:0]    main_wr_ptr_reg, main_rd_ptr_reg;
  logic [main_aw:0]      main_cnt_reg, main_cnt_next;
  logic                  main_empty, main_push;
  logic                  error_main_reg;
  logic [data_width-1:0] main_head;

  // Transfer stage and per-VC views
  logic                  xfer, xfer_tgt;
  logic [1:0]            vc_pop_req;
  logic [1:0]            vc_empty;
  logic [1:0]            vc_err;
  logic [vc_aw:0]        vc_cnt  [2];
  logic [data_width-1:0] vc_head [2];
`ifdef INITIAL_LOGIC_STATS_EN
  logic [7:0]            routed_cnt [2];
`endif

  assign main_empty       = (main_cnt_reg == '0);
  assign full_main        = (main_cnt_reg == MAIN_FULL);
  assign almost_full_main = (main_cnt_reg >= MAIN_AF);
  assign main_head        = main_mem[main_rd_ptr_reg];

  // Strict order: only the head may move, and only into a VC with headroom.
  assign xfer_tgt  = main_head[VC_BIT];
  assign xfer      = !main_empty && (vc_cnt[xfer_tgt] < VC_LIMIT);
  assign main_push = push_main && (!full_main || xfer);

  always_comb begin
    main_cnt_next = main_cnt_reg;
    if (main_push && !xfer)
      main_cnt_next = main_cnt_reg + 1'b1;
    else if (!main_push && xfer)
      main_cnt_next = main_cnt_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      main_wr_ptr_reg <= '0;
      main_rd_ptr_reg <= '0;
      main_cnt_reg    <= '0;
      error_main_reg  <= 1'b0;
    end else begin
      if (main_push)
        main_wr_ptr_reg <= main_wr_ptr_reg + 1'b1;
      if (xfer)
        main_rd_ptr_reg <= main_rd_ptr_reg + 1'b1;
      main_cnt_reg <= main_cnt_next;
      if (push_main && !main_push)
        error_main_reg <= 1'b1;
    end
  end

  // When full, the write lands on the slot the transfer is vacating this edge.
  always_ff @(posedge clk) begin
    if (main_push)
      main_mem[main_wr_ptr_reg] <= data_in;
  end

  assign error_main = error_main_reg;
  assign vc_pop_req = {pop_VC1, pop_VC0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      logic [data_width-1:0] mem [VC_DEPTH];
      logic [vc_aw-1:0]      wr_ptr_reg, rd_ptr_reg;
      logic [vc_aw:0]        cnt_reg, cnt_next;
      logic                  push, pop, err_reg;

      assign push = xfer && (xfer_tgt == 1'(gi));
      assign pop  = vc_pop_req[gi] && !vc_empty[gi];

      always_comb begin
        cnt_next = cnt_reg;
        if (push && !pop)
          cnt_next = cnt_reg + 1'b1;
        else if (!push && pop)
          cnt_next = cnt_reg - 1'b1;
      end

      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
          err_reg    <= 1'b0;
        end else begin
          if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          cnt_reg <= cnt_next;
          if (vc_pop_req[gi] && vc_empty[gi])
            err_reg <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push)
          mem[wr_ptr_reg] <= main_head;
      end

      assign vc_cnt[gi]   = cnt_reg;
      assign vc_empty[gi] = (cnt_reg == '0);
      assign vc_head[gi]  = vc_empty[gi] ? '0 : mem[rd_ptr_reg];
      assign vc_err[gi]   = err_reg;

`ifdef INITIAL_LOGIC_STATS_EN
      logic [7:0] routed_reg;
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
          routed_reg <= '0;
        else if (push && (routed_reg != 8'hFF))
          routed_reg <= routed_reg + 1'b1;
      end
      assign routed_cnt[gi] = routed_reg;
`endif
    end
  endgenerate

  assign data_out_VC0   = vc_head[0];
  assign data_out_VC1   = vc_head[1];
  assign empty_fifo_VC0 = vc_empty[0];
  assign empty_fifo_VC1 = vc_empty[1];
  assign error_VC0      = vc_err[0];
  assign error_VC1      = vc_err[1];
`ifdef INITIAL_LOGIC_STATS_EN
  assign routed_VC0     = routed_cnt[0];
  assign routed_VC1     = routed_cnt[1];
`endif

endmodule
